// File: rtl/rgu_pkg.sv
// Shared types and register map for the reset generation unit (RGU) APB requester.
package rgu_pkg;

    localparam int RGU_ADDR_W = 12;
    localparam int RGU_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // RGU register offsets (byte addresses, word aligned)
    localparam logic [RGU_ADDR_W-1:0] RGU_GLB                   = 12'h000;
    localparam logic [RGU_ADDR_W-1:0] RGU_RST_STATUS            = 12'h004;
    localparam logic [RGU_ADDR_W-1:0] RGU_TIMER0                = 12'h008;
    localparam logic [RGU_ADDR_W-1:0] RGU_TIMER1                = 12'h00C;
    localparam logic [RGU_ADDR_W-1:0] RGU_SB_SWRST              = 12'h010;
    localparam logic [RGU_ADDR_W-1:0] RGU_DDR_SWRST             = 12'h014;
    localparam logic [RGU_ADDR_W-1:0] RGU_USB0_SWRST            = 12'h018;
    localparam logic [RGU_ADDR_W-1:0] RGU_USB1_SWRST            = 12'h01C;
    localparam logic [RGU_ADDR_W-1:0] RGU_GMAC_SWRST            = 12'h020;
    localparam logic [RGU_ADDR_W-1:0] RGU_SDIO_SWRST            = 12'h024;
    localparam logic [RGU_ADDR_W-1:0] RGU_SPI_SWRST             = 12'h028;
    localparam logic [RGU_ADDR_W-1:0] RGU_I2C_SWRST             = 12'h02C;
    localparam logic [RGU_ADDR_W-1:0] RGU_UART_SWRST            = 12'h030;
    localparam logic [RGU_ADDR_W-1:0] RGU_GPIO_SWRST            = 12'h034;
    localparam logic [RGU_ADDR_W-1:0] RGU_TIMER_SWRST           = 12'h038;
    localparam logic [RGU_ADDR_W-1:0] RGU_WDT_SWRST             = 12'h03C;
    localparam logic [RGU_ADDR_W-1:0] RGU_DMA_SWRST             = 12'h040;
    localparam logic [RGU_ADDR_W-1:0] RGU_CRYPTO_SWRST          = 12'h044;
    localparam logic [RGU_ADDR_W-1:0] RGU_VPU_SWRST             = 12'h048;
    localparam logic [RGU_ADDR_W-1:0] RGU_GPU_SWRST             = 12'h04C;
    localparam logic [RGU_ADDR_W-1:0] RGU_DISP_SWRST            = 12'h050;
    localparam logic [RGU_ADDR_W-1:0] RGU_CAM_SWRST             = 12'h054;
    localparam logic [RGU_ADDR_W-1:0] RGU_AUDIO_SWRST           = 12'h058;
    localparam logic [RGU_ADDR_W-1:0] RGU_PCIE_SWRST            = 12'h05C;
    localparam logic [RGU_ADDR_W-1:0] RGU_CPU_DBG_SWRST         = 12'h060;
    localparam logic [RGU_ADDR_W-1:0] RGU_CPU_PWRUP_LIGHT_SWRST = 12'h064;
    localparam logic [RGU_ADDR_W-1:0] RGU_CPU_PWRUP_HEAVY_SWRST = 12'h068;

endpackage

// File: rtl/rgu_apb_master.sv
// APB3 requester: turns one valid/ready command into one SETUP/ACCESS transfer
// and returns a single-cycle response with read data and error/timeout status.
module rgu_apb_master
    import rgu_pkg::*;
#(
    parameter int ADDR_W  = RGU_ADDR_W,
    parameter int DATA_W  = RGU_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t       state;
    apb_state_t       state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic             accept;
    logic             aligned;
    logic             timeout_hit;

    assign cmd_ready   = (state == IDLE) && !PRESET;
    assign busy        = (state != IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign aligned     = (cmd_addr[1:0] == 2'b00);
    // to_cnt counts earlier stalled ACCESS cycles, so TO_LAST marks the TIMEOUT-th one
    assign timeout_hit = (TIMEOUT > 0) && !PREADY && (to_cnt == TO_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = aligned ? SETUP : RESP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && aligned) begin
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_wdata;
                        PSEL   <= 1'b1;
                    end else if (accept) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                    end
                end
                SETUP: PENABLE <= 1'b1;
                ACCESS: begin
                    // PREADY takes priority over a timeout landing in the same cycle
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    end else if (timeout_hit) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET || state_nxt == SETUP)
            to_cnt <= '0;
        else if ((TIMEOUT > 0) && state == ACCESS && !PREADY && to_cnt != TO_LAST)
            to_cnt <= to_cnt + 1'b1;
    end

endmodule

// File: tb/tb_rgu_apb_master.sv
// Directed bench for rgu_apb_master: driver pushes expected responses into a
// scoreboard queue, a monitor pops and compares on every rsp_valid pulse.
module tb_rgu_apb_master;
    import rgu_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;
    logic              PSLVERR = 1'b0;
    logic              busy;

    always #5 PCLK = ~PCLK;

    rgu_apb_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .busy       (busy)
    );

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              tmo;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // slave behaviour and expected APB fields for the command in flight
    int                slv_waits = 0;
    bit                slv_hang = 1'b0;
    logic [DATA_W-1:0] slv_rdata = '0;
    logic              slv_err = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic              exp_write = 1'b0;
    logic [DATA_W-1:0] exp_wdata = '0;
    int                acc_cnt = 0;
    int                last_acc_len = 0;
    int                psel_cycles = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB slave: responds at negedge so the DUT samples stable values at posedge
    initial forever begin
        @(negedge PCLK);
        if (mon_en && PSEL === 1'b1) begin
            psel_cycles++;
            check("PADDR_stable", PADDR, exp_addr);
            check("PWRITE_stable", PWRITE, exp_write);
            if (exp_write) check("PWDATA_stable", PWDATA, exp_wdata);
        end
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            PREADY  = !slv_hang && (acc_cnt == slv_waits);
            PSLVERR = slv_err;
            PRDATA  = slv_rdata;
            acc_cnt++;
            last_acc_len = acc_cnt;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
    end

    // response monitor / scoreboard
    initial forever begin
        exp_t e;
        @(negedge PCLK);
        if (mon_en) begin
            check("PENABLE_without_PSEL", PENABLE && !PSEL, 0);
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_valid with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input int waits, input bit hang, input logic [DATA_W-1:0] srdata, input logic serr,
                         input logic [DATA_W-1:0] e_rdata, input logic e_err, input logic e_tmo,
                         input int lat, input bit do_rsp, output int acc_cyc);
        exp_t e;
        int   n = 0;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("cmd_accept_in_budget", n < 200, 1);
        acc_cyc   = cyc;
        slv_waits = waits;
        slv_hang  = hang;
        slv_rdata = srdata;
        slv_err   = serr;
        exp_addr  = addr;
        exp_write = wr;
        exp_wdata = wdata;
        if (do_rsp) begin
            e.rdata = e_rdata;
            e.err   = e_err;
            e.tmo   = e_tmo;
            e.cyc   = acc_cyc + lat;
            sb.push_back(e);
        end
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("idle_after_drain", busy, 0);
    endtask

    initial begin
        int c1;
        int c2;
        int p0;

        // reset state
        repeat (2) @(posedge PCLK);
        mon_en = 1'b1;
        @(negedge PCLK);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_PSEL", PSEL, 0);
        check("rst_PENABLE", PENABLE, 0);
        check("rst_PWRITE", PWRITE, 0);
        check("rst_PADDR", PADDR, 0);
        check("rst_PWDATA", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("idle_cmd_ready", cmd_ready, 1);

        // zero-wait write: SETUP in N+1, ACCESS in N+2, response in N+3
        issue(1'b1, RGU_DDR_SWRST, 32'h0000_00A5, 0, 1'b0, 32'hFFFF_FFFF, 1'b0,
              32'h0, 1'b0, 1'b0, 3, 1'b1, c1);
        check("wr_setup_PSEL", PSEL, 1);
        check("wr_setup_PENABLE", PENABLE, 0);
        @(negedge PCLK);
        check("wr_access_PENABLE", PENABLE, 1);
        wait_done();

        // read with three wait states
        issue(1'b0, RGU_RST_STATUS, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0,
              32'h1234_5678, 1'b0, 1'b0, 6, 1'b1, c1);
        wait_done();
        check("wait3_access_len", last_acc_len, 4);

        // slave error: read data suppressed
        issue(1'b0, 12'h0FC, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1,
              32'h0, 1'b1, 1'b0, 3, 1'b1, c1);
        wait_done();

        // stalled slave: timeout after exactly 64 ACCESS cycles
        issue(1'b0, RGU_SB_SWRST, 32'h0, 0, 1'b1, 32'h5555_AAAA, 1'b0,
              32'h0, 1'b1, 1'b1, 66, 1'b1, c1);
        wait_done();
        check("timeout_access_len", last_acc_len, 64);

        // PREADY arriving in the 64th ACCESS cycle completes normally
        issue(1'b0, RGU_SB_SWRST, 32'h0, 63, 1'b0, 32'hCAFE_0001, 1'b0,
              32'hCAFE_0001, 1'b0, 1'b0, 66, 1'b1, c1);
        wait_done();
        check("late_ready_access_len", last_acc_len, 64);

        // misaligned address: no APB transfer, error response in N+1
        p0 = psel_cycles;
        issue(1'b0, 12'h006, 32'h0, 0, 1'b0, 32'h1111_1111, 1'b0,
              32'h0, 1'b1, 1'b0, 1, 1'b1, c1);
        @(negedge PCLK);
        check("misaligned_ready_N2", cmd_ready, 1);
        wait_done();
        check("misaligned_no_psel", psel_cycles - p0, 0);

        // reset during ACCESS aborts without a response
        issue(1'b0, RGU_TIMER0, 32'h0, 0, 1'b1, 32'h0, 1'b0,
              32'h0, 1'b0, 1'b0, 0, 1'b0, c1);
        @(negedge PCLK);
        check("abort_in_access", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("abort_PSEL", PSEL, 0);
        check("abort_PENABLE", PENABLE, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_busy", busy, 0);
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);

        // back-to-back zero-wait reads, four cycles each
        issue(1'b0, RGU_GLB, 32'h0, 0, 1'b0, 32'h0000_0001, 1'b0,
              32'h0000_0001, 1'b0, 1'b0, 3, 1'b1, c1);
        issue(1'b0, RGU_TIMER1, 32'h0, 0, 1'b0, 32'h0000_00C0, 1'b0,
              32'h0000_00C0, 1'b0, 1'b0, 3, 1'b1, c2);
        check("b2b_spacing", c2 - c1, 4);
        wait_done();
        repeat (3) @(negedge PCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
